ifetch_queue: RTL and testbench

IFETCH_QUEUE -- requirements
Module: ifetch_queue

---
 rtl/ifq_pkg.sv | 26 ++
 rtl/ifetch_queue_if.sv | 28 ++
 rtl/ifq_line_ram.sv | 24 ++
 rtl/ifetch_queue.sv | 129 ++++++++++++
 tb/tb_ifetch_queue.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ifq_pkg.sv
// rtl/ifq_pkg.sv - shared sizes, fetch FSM encoding and line word helper for the fetch queue
package ifq_pkg;

  localparam int IFQ_DEPTH      = 4;
  localparam int LINE_W         = 128;
  localparam int WORDS_PER_LINE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  // Word k of a cache line sits at bits [32k+31:32k].
  function automatic logic [31:0] line_word(input logic [LINE_W-1:0] line, input logic [1:0] idx);
    logic [31:0] word;
    case (idx)
      2'd0:    word = line[31:0];
      2'd1:    word = line[63:32];
      2'd2:    word = line[95:64];
      default: word = line[127:96];
    endcase
    return word;
  endfunction

endpackage

// File: rtl/ifetch_queue_if.sv
// rtl/ifetch_queue_if.sv - cache request/response and dispatch handshake bundle for the fetch queue
interface ifetch_queue_if;
  import ifq_pkg::*;

  logic [31:0]       Ifq_pc_out;
  logic              Ifq_rd_en;
  logic [LINE_W-1:0] Icache_dout;
  logic              Icache_dout_valid;
  logic [31:0]       ifetch_intruction;
  logic [31:0]       ifetch_pc_4;
  logic              ifetch_empty;
  logic              Dispatch_ren;
  logic              Dispatch_jmp;
  logic [31:0]       Dispatch_jmp_addr;

  // The fetch queue side of the bundle.
  modport master (
    output Ifq_pc_out, Ifq_rd_en, ifetch_intruction, ifetch_pc_4, ifetch_empty,
    input  Icache_dout, Icache_dout_valid, Dispatch_ren, Dispatch_jmp, Dispatch_jmp_addr
  );

  // The cache / dispatch side of the bundle.
  modport slave (
    input  Ifq_pc_out, Ifq_rd_en, ifetch_intruction, ifetch_pc_4, ifetch_empty,
    output Icache_dout, Icache_dout_valid, Dispatch_ren, Dispatch_jmp, Dispatch_jmp_addr
  );

endinterface

// File: rtl/ifq_line_ram.sv
// rtl/ifq_line_ram.sv - 4 x 128-bit line store, synchronous write, asynchronous read
module ifq_line_ram
  import ifq_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [1:0]        waddr,
  input  logic [LINE_W-1:0] wdata,
  input  logic [1:0]        raddr,
  output logic [LINE_W-1:0] rdata
);

  logic [LINE_W-1:0] mem [IFQ_DEPTH];

  // Line write on the clock edge; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - instruction fetch queue: line prefetch FSM, 4-line buffer, word-granular dispatch
module ifetch_queue
  import ifq_pkg::*;
(
  input  logic           clock,
  input  logic           reset,
  ifetch_queue_if.master bus
);

  fetch_state_t      state_q;
  fetch_state_t      state_d;
  logic [2:0]        wp;
  logic [2:0]        rp;
  logic [1:0]        off;
  logic [31:0]       rd_pc;
  logic [31:0]       fetch_pc;
  logic [31:0]       req_addr;
  logic              empty;
  logic              full;
  logic              line_we;
  logic              req_latch;
  logic              do_pop;
  logic [LINE_W-1:0] head_line;
  logic [31:0]       head_word;
  logic              unused_addr_bits;

  // Redirect targets are word aligned; the low two address bits carry no information.
  assign unused_addr_bits = ^bus.Dispatch_jmp_addr[1:0];

  // Pointer compare uses registered pointers only, so same-cycle write/free do not interact.
  assign empty  = (wp == rp);
  assign full   = (wp[1:0] == rp[1:0]) && (wp[2] != rp[2]);
  assign do_pop = bus.Dispatch_ren && !empty && !bus.Dispatch_jmp;

  ifq_line_ram u_line_ram (
    .clk   (clock),
    .we    (line_we),
    .waddr (wp[1:0]),
    .wdata (bus.Icache_dout),
    .raddr (rp[1:0]),
    .rdata (head_line)
  );

  // Fetch FSM state register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Fetch FSM next state, line write strobe and request address latch.
  always_comb begin
    state_d   = state_q;
    line_we   = 1'b0;
    req_latch = 1'b0;
    case (state_q)
      IDLE: begin
        if (!bus.Dispatch_jmp && !full) begin
          state_d   = REQ;
          req_latch = 1'b1;
        end
      end
      REQ: begin
        if (bus.Dispatch_jmp) begin
          // A redirect kills the line in flight; if it has not arrived yet, wait it out.
          state_d = bus.Icache_dout_valid ? IDLE : DROP;
        end else if (bus.Icache_dout_valid) begin
          line_we = 1'b1;
          state_d = IDLE;
        end
      end
      DROP: begin
        if (bus.Icache_dout_valid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Queue pointers, PCs and request address; a redirect overrides every other update.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wp       <= 3'd0;
      rp       <= 3'd0;
      off      <= 2'd0;
      rd_pc    <= 32'd0;
      fetch_pc <= 32'd0;
      req_addr <= 32'd0;
    end else begin
      if (req_latch) begin
        req_addr <= fetch_pc;
      end
      if (bus.Dispatch_jmp) begin
        wp       <= 3'd0;
        rp       <= 3'd0;
        off      <= bus.Dispatch_jmp_addr[3:2];
        rd_pc    <= {bus.Dispatch_jmp_addr[31:2], 2'b00};
        fetch_pc <= {bus.Dispatch_jmp_addr[31:4], 4'h0};
      end else begin
        if (line_we) begin
          wp       <= wp + 3'd1;
          fetch_pc <= fetch_pc + 32'd16;
        end
        if (do_pop) begin
          rd_pc <= rd_pc + 32'd4;
          off   <= off + 2'd1;
          if (off == 2'd3) begin
            rp <= rp + 3'd1;
          end
        end
      end
    end
  end

  // Head word of the oldest line, selected by the word offset.
  always_comb begin
    head_word = line_word(head_line, off);
  end

  assign bus.Ifq_rd_en         = (state_q == REQ) || (state_q == DROP);
  assign bus.Ifq_pc_out        = req_addr;
  assign bus.ifetch_empty      = empty;
  assign bus.ifetch_intruction = empty ? 32'h0 : head_word;
  assign bus.ifetch_pc_4       = rd_pc + 32'd4;

endmodule

// File: tb/tb_ifetch_queue.sv
// tb/tb_ifetch_queue.sv - directed self-checking bench for ifetch_queue
module tb_ifetch_queue;
  import ifq_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  ifetch_queue_if bus();

  ifetch_queue dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp      = 0;
  int n_bad      = 0;
  bit cache_en   = 1'b0;
  int cache_wait = 1;
  int line_count = 0;

  // Cache content model: the word at byte address pc holds pc/4 + 1.
  function automatic logic [31:0] exp_word(input logic [31:0] pc);
    return {2'b00, pc[31:2]} + 32'd1;
  endfunction

  function automatic logic [127:0] line_for(input logic [31:0] a);
    logic [31:0] b;
    b = {a[31:4], 4'h0};
    return {exp_word(b + 32'd12), exp_word(b + 32'd8), exp_word(b + 32'd4), exp_word(b)};
  endfunction

  // Cache responder: answers a request cache_wait cycles after it is first seen.
  initial begin : cache_model
    int cnt;
    cnt = 0;
    bus.Icache_dout       = '0;
    bus.Icache_dout_valid = 1'b0;
    forever begin
      @(negedge clk);
      bus.Icache_dout_valid = 1'b0;
      if (cache_en && bus.Ifq_rd_en) begin
        if (cnt >= cache_wait) begin
          bus.Icache_dout       = line_for(bus.Ifq_pc_out);
          bus.Icache_dout_valid = 1'b1;
          line_count++;
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n                 = 1'b0;
    cache_en              = 1'b0;
    bus.Dispatch_ren      = 1'b0;
    bus.Dispatch_jmp      = 1'b0;
    bus.Dispatch_jmp_addr = 32'h0;
    tick();
    tick();
  endtask

  task automatic release_reset(input int wt);
    cache_wait = wt;
    cache_en   = 1'b1;
    rst_n      = 1'b1;
  endtask

  task automatic wait_rd_en(input logic lvl, input string what);
    int i;
    i = 0;
    while (bus.Ifq_rd_en !== lvl && i < 200) begin
      tick();
      i++;
    end
    if (bus.Ifq_rd_en !== lvl) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: Ifq_rd_en stuck at %0b, wanted %0b", what, bus.Ifq_rd_en, lvl);
    end
  endtask

  task automatic wait_not_empty(input string what);
    int i;
    i = 0;
    while (bus.ifetch_empty !== 1'b0 && i < 200) begin
      tick();
      i++;
    end
    if (bus.ifetch_empty !== 1'b0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: ifetch_empty stuck at %0b, wanted 0", what, bus.ifetch_empty);
    end
  endtask

  task automatic wait_valid(input string what);
    int i;
    i = 0;
    while (bus.Icache_dout_valid !== 1'b1 && i < 200) begin
      tick();
      i++;
    end
    if (bus.Icache_dout_valid !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no cache response seen", what);
    end
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    n_cmp++; if (bus.Ifq_rd_en !== 1'b0) begin n_bad++; $display("FAIL reset_rd_en: got %0b want 0", bus.Ifq_rd_en); end
    n_cmp++; if (bus.Ifq_pc_out !== 32'h0) begin n_bad++; $display("FAIL reset_pc_out: got %h want 0", bus.Ifq_pc_out); end
    n_cmp++; if (bus.ifetch_empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty: got %0b want 1", bus.ifetch_empty); end
    n_cmp++; if (bus.ifetch_intruction !== 32'h0) begin n_bad++; $display("FAIL reset_instr: got %h want 0", bus.ifetch_intruction); end
    n_cmp++; if (bus.ifetch_pc_4 !== 32'h4) begin n_bad++; $display("FAIL reset_pc_4: got %h want 4", bus.ifetch_pc_4); end
  endtask

  task automatic test_first_fetch();
    line_count = 0;
    release_reset(1);
    wait_rd_en(1'b1, "first_req");
    n_cmp++; if (bus.Ifq_pc_out !== 32'h0) begin n_bad++; $display("FAIL first_pc_out: got %h want 0", bus.Ifq_pc_out); end
    wait_not_empty("first_line");
    n_cmp++; if (bus.ifetch_intruction !== 32'h1) begin n_bad++; $display("FAIL first_instr: got %h want 1", bus.ifetch_intruction); end
    n_cmp++; if (bus.ifetch_pc_4 !== 32'h4) begin n_bad++; $display("FAIL first_pc_4: got %h want 4", bus.ifetch_pc_4); end
    n_cmp++; if (bus.ifetch_empty !== 1'b0) begin n_bad++; $display("FAIL first_empty: got %0b want 0", bus.ifetch_empty); end
  endtask

  task automatic test_fill();
    bus.Dispatch_ren = 1'b0;
    repeat (40) tick();
    n_cmp++; if (bus.Ifq_rd_en !== 1'b0) begin n_bad++; $display("FAIL fill_rd_en: got %0b want 0", bus.Ifq_rd_en); end
    n_cmp++; if (line_count !== 4) begin n_bad++; $display("FAIL fill_lines: got %0d want 4", line_count); end
    bus.Dispatch_ren = 1'b1;
    tick();
    bus.Dispatch_ren = 1'b0;
    n_cmp++; if (bus.ifetch_intruction !== 32'h2) begin n_bad++; $display("FAIL one_ren_instr: got %h want 2", bus.ifetch_intruction); end
    n_cmp++; if (bus.ifetch_pc_4 !== 32'h8) begin n_bad++; $display("FAIL one_ren_pc_4: got %h want 8", bus.ifetch_pc_4); end
    repeat (5) tick();
    n_cmp++; if (bus.Ifq_rd_en !== 1'b0) begin n_bad++; $display("FAIL one_ren_no_free: got rd_en %0b want 0", bus.Ifq_rd_en); end
    n_cmp++; if (line_count !== 4) begin n_bad++; $display("FAIL one_ren_lines: got %0d want 4", line_count); end
    bus.Dispatch_ren = 1'b1;
    repeat (3) tick();
    bus.Dispatch_ren = 1'b0;
    n_cmp++; if (bus.ifetch_intruction !== 32'h5) begin n_bad++; $display("FAIL wrap_instr: got %h want 5", bus.ifetch_intruction); end
    n_cmp++; if (bus.ifetch_pc_4 !== 32'h14) begin n_bad++; $display("FAIL wrap_pc_4: got %h want 14", bus.ifetch_pc_4); end
    wait_rd_en(1'b1, "refill_req");
    n_cmp++; if (bus.Ifq_pc_out !== 32'h40) begin n_bad++; $display("FAIL refill_pc_out: got %h want 40", bus.Ifq_pc_out); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_pc;
    int n;
    int guard;
    do_reset();
    release_reset(1);
    bus.Dispatch_ren = 1'b1;
    exp_pc = 32'h0;
    n      = 0;
    guard  = 0;
    while (n < 16 && guard < 400) begin
      tick();
      guard++;
      if (bus.ifetch_empty === 1'b0) begin
        n_cmp++; if (bus.ifetch_intruction !== exp_word(exp_pc)) begin n_bad++; $display("FAIL stream_instr[%0d]: got %h want %h", n, bus.ifetch_intruction, exp_word(exp_pc)); end
        n_cmp++; if (bus.ifetch_pc_4 !== exp_pc + 32'd4) begin n_bad++; $display("FAIL stream_pc_4[%0d]: got %h want %h", n, bus.ifetch_pc_4, exp_pc + 32'd4); end
        exp_pc = exp_pc + 32'd4;
        n++;
        if (n == 16) bus.Dispatch_ren = 1'b0;
      end
    end
    bus.Dispatch_ren = 1'b0;
    if (n < 16) begin
      n_cmp++;
      n_bad++;
      $display("FAIL stream_count: got %0d words want 16", n);
    end
  endtask

  task automatic test_jump_req();
    do_reset();
    release_reset(3);
    wait_rd_en(1'b1, "jreq_req");
    bus.Dispatch_jmp      = 1'b1;
    bus.Dispatch_jmp_addr = 32'h0000_0128;
    tick();
    bus.Dispatch_jmp = 1'b0;
    n_cmp++; if (bus.Ifq_rd_en !== 1'b1) begin n_bad++; $display("FAIL jreq_drop_rd_en: got %0b want 1", bus.Ifq_rd_en); end
    n_cmp++; if (bus.Ifq_pc_out !== 32'h0) begin n_bad++; $display("FAIL jreq_drop_pc_out: got %h want 0", bus.Ifq_pc_out); end
    n_cmp++; if (bus.ifetch_empty !== 1'b1) begin n_bad++; $display("FAIL jreq_drop_empty: got %0b want 1", bus.ifetch_empty); end
    wait_rd_en(1'b0, "jreq_drop_end");
    n_cmp++; if (bus.ifetch_empty !== 1'b1) begin n_bad++; $display("FAIL jreq_discard: got empty %0b want 1", bus.ifetch_empty); end
    wait_rd_en(1'b1, "jreq_target_req");
    n_cmp++; if (bus.Ifq_pc_out !== 32'h120) begin n_bad++; $display("FAIL jreq_pc_out: got %h want 120", bus.Ifq_pc_out); end
    wait_not_empty("jreq_target_line");
    n_cmp++; if (bus.ifetch_intruction !== 32'h4B) begin n_bad++; $display("FAIL jreq_instr: got %h want 4b", bus.ifetch_intruction); end
    n_cmp++; if (bus.ifetch_pc_4 !== 32'h12C) begin n_bad++; $display("FAIL jreq_pc_4: got %h want 12c", bus.ifetch_pc_4); end
  endtask

  task automatic test_jump_valid();
    do_reset();
    release_reset(1);
    wait_valid("jval_valid");
    bus.Dispatch_jmp      = 1'b1;
    bus.Dispatch_jmp_addr = 32'h0000_0040;
    tick();
    bus.Dispatch_jmp = 1'b0;
    n_cmp++; if (bus.ifetch_empty !== 1'b1) begin n_bad++; $display("FAIL jval_empty: got %0b want 1", bus.ifetch_empty); end
    n_cmp++; if (bus.Ifq_rd_en !== 1'b0) begin n_bad++; $display("FAIL jval_idle: got rd_en %0b want 0", bus.Ifq_rd_en); end
    wait_rd_en(1'b1, "jval_target_req");
    n_cmp++; if (bus.Ifq_pc_out !== 32'h40) begin n_bad++; $display("FAIL jval_pc_out: got %h want 40", bus.Ifq_pc_out); end
    wait_not_empty("jval_target_line");
    n_cmp++; if (bus.ifetch_intruction !== 32'h11) begin n_bad++; $display("FAIL jval_instr: got %h want 11", bus.ifetch_intruction); end
    n_cmp++; if (bus.ifetch_pc_4 !== 32'h44) begin n_bad++; $display("FAIL jval_pc_4: got %h want 44", bus.ifetch_pc_4); end
  endtask

  task automatic test_reset_mid_req();
    int guard;
    do_reset();
    release_reset(1);
    bus.Dispatch_ren = 1'b1;
    guard = 0;
    while (!(bus.ifetch_pc_4 >= 32'h20 && bus.Ifq_rd_en === 1'b1 && bus.Icache_dout_valid === 1'b0) && guard < 300) begin
      tick();
      guard++;
    end
    if (guard >= 300) begin
      n_cmp++;
      n_bad++;
      $display("FAIL rmid_setup: never reached a mid-request point");
    end
    rst_n            = 1'b0;
    cache_en         = 1'b0;
    bus.Dispatch_ren = 1'b0;
    tick();
    n_cmp++; if (bus.Ifq_rd_en !== 1'b0) begin n_bad++; $display("FAIL rmid_rd_en: got %0b want 0", bus.Ifq_rd_en); end
    n_cmp++; if (bus.Ifq_pc_out !== 32'h0) begin n_bad++; $display("FAIL rmid_pc_out: got %h want 0", bus.Ifq_pc_out); end
    n_cmp++; if (bus.ifetch_empty !== 1'b1) begin n_bad++; $display("FAIL rmid_empty: got %0b want 1", bus.ifetch_empty); end
    n_cmp++; if (bus.ifetch_intruction !== 32'h0) begin n_bad++; $display("FAIL rmid_instr: got %h want 0", bus.ifetch_intruction); end
    n_cmp++; if (bus.ifetch_pc_4 !== 32'h4) begin n_bad++; $display("FAIL rmid_pc_4: got %h want 4", bus.ifetch_pc_4); end
    release_reset(1);
    wait_rd_en(1'b1, "rmid_resume_req");
    n_cmp++; if (bus.Ifq_pc_out !== 32'h0) begin n_bad++; $display("FAIL rmid_resume_pc_out: got %h want 0", bus.Ifq_pc_out); end
    wait_not_empty("rmid_resume_line");
    n_cmp++; if (bus.ifetch_intruction !== 32'h1) begin n_bad++; $display("FAIL rmid_resume_instr: got %h want 1", bus.ifetch_intruction); end
    n_cmp++; if (bus.ifetch_pc_4 !== 32'h4) begin n_bad++; $display("FAIL rmid_resume_pc_4: got %h want 4", bus.ifetch_pc_4); end
  endtask

  initial begin
    bus.Dispatch_ren      = 1'b0;
    bus.Dispatch_jmp      = 1'b0;
    bus.Dispatch_jmp_addr = 32'h0;
    test_reset();
    test_first_fetch();
    test_fill();
    test_back_to_back();
    test_jump_req();
    test_jump_valid();
    test_reset_mid_req();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
